sort_serial_tx: RTL and testbench

SORT_SERIAL_TX -- requirements
Module: sort_serial_tx

---
 rtl/sort_serial_tx_pkg.sv | 22 ++
 rtl/sort_serial_tx_cmp_swap.sv | 23 ++
 rtl/sort_serial_tx.sv | 121 ++++++++++++
 tb/tb_sort_serial_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_serial_tx_pkg.sv
// Shared types and constants for the serial 4-element sorter.
// Holds the FSM state enum, the element count and the compare-swap schedule.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        SEND
    } state_t;

    localparam int N_ELEM  = 4;
    localparam int N_STEPS = 6;
    localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

    // Pair index j for each sort step, step 0 in the least significant bits: 0,1,2,0,1,0
    localparam logic [11:0] CMP_SCHED = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] sched_j(input logic [2:0] step);
        return CMP_SCHED[{step, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/sort_serial_tx_cmp_swap.sv
// Combinational compare-swap of two unsigned elements; o_a/o_b leave in sorted order.
// SORT_SERIAL_DESC_EN flips the order to descending. Equal values never swap.
module cmp_swap #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    logic w_swap;

`ifdef SORT_SERIAL_DESC_EN
    assign w_swap = (i_a < i_b);
`else
    assign w_swap = (i_a > i_b);
`endif

    assign o_a = w_swap ? i_b : i_a;
    assign o_b = w_swap ? i_a : i_b;

endmodule

// File: rtl/sort_serial_tx.sv
// Accepts a packed 4-element word, bubble-sorts it with one shared compare-swap over 6 cycles,
// then streams the elements out one per handshake. SORT_SERIAL_DESC_EN selects descending order.
module sort_serial_tx
    import sort_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [4*W-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last
);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_e [N_ELEM];
    logic [2:0]     r_step;
    logic [1:0]     r_idx;

    logic [1:0]     w_j;
    logic [1:0]     w_j1;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [W-1:0]   w_lo;
    logic [W-1:0]   w_hi;
    logic           w_accept;

    assign w_j      = sched_j(r_step);
    assign w_j1     = w_j + 2'd1;
    assign w_a      = r_e[w_j];
    assign w_b      = r_e[w_j1];
    assign w_accept = in_valid && (r_state == IDLE);

    cmp_swap #(.W(W)) u_cmp_swap (
        .i_a (w_a),
        .i_b (w_b),
        .o_a (w_lo),
        .o_b (w_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = SORT;
                end
            end
            SORT: begin
                if (r_step == LAST_STEP) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = r_e[r_idx];
                out_last  = (r_idx == 2'd3);
                if (out_ready && (r_idx == 2'd3)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Element storage: loaded on accept, rewritten by the shared compare-swap during SORT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ELEM; k++) begin
                r_e[k] <= '0;
            end
            r_step <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < N_ELEM; k++) begin
                            r_e[k] <= in_data[k*W +: W];
                        end
                    end
                    r_step <= '0;
                    r_idx  <= '0;
                end
                SORT: begin
                    r_e[w_j]  <= w_lo;
                    r_e[w_j1] <= w_hi;
                    r_step    <= r_step + 3'd1;
                end
                SEND: begin
                    if (out_ready) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: begin
                    r_step <= '0;
                    r_idx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_serial_tx.sv
// Directed testbench for sort_serial_tx; expectations follow SORT_SERIAL_DESC_EN when defined.
module tb_sort_serial_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    sort_serial_tx #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // asc lists the ascending order with the smallest element in the top nibble
    function automatic logic [3:0] expAt(input logic [15:0] asc, input int k);
`ifdef SORT_SERIAL_DESC_EN
        return asc[(k * 4) +: 4];
`else
        return asc[(12 - k * 4) +: 4];
`endif
    endfunction

    // Accepts one word, checks the 6-cycle sort latency, then streams with the given out_ready pattern
    task automatic sendWord(input logic [15:0] word, input logic [15:0] asc,
                            input logic [7:0] readyPat, input string label);
        int sent;
        int c;
        logic [3:0] exp;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s.in_ready_idle got=%b want=1", label, in_ready);
        end
        in_data   = word;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        in_data   = 16'hDEAD;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s.in_ready_busy got=%b want=0", label, in_ready);
        end
        for (int e = 0; e < 6; e++) begin
            checks++;
            if (out_valid !== 1'b0 || out_data !== 4'h0) begin
                errors++;
                $display("[TB] FAIL %s.sort_quiet cyc=%0d valid=%b data=%h want valid=0 data=0",
                         label, e, out_valid, out_data);
            end
            tick();
        end
        sent = 0;
        c = 0;
        while (sent < 4 && c < 40) begin
            out_ready = (c < 8) ? readyPat[c] : 1'b1;
            exp = expAt(asc, sent);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || out_last !== (sent == 3)) begin
                errors++;
                $display("[TB] FAIL %s.elem%0d valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                         label, sent, out_valid, out_data, out_last, exp, (sent == 3));
            end
            tick();
            if (out_ready) sent++;
            c++;
        end
        out_ready = 1'b0;
        checks++;
        if (sent != 4) begin
            errors++;
            $display("[TB] FAIL %s.timeout sent=%0d want=4", label, sent);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s.back_idle rdy=%b valid=%b data=%h last=%b want 1,0,0,0",
                     label, in_ready, out_valid, out_data, out_last);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset.outputs rdy=%b valid=%b data=%h last=%b want 1,0,0,0",
                     in_ready, out_valid, out_data, out_last);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset.release rdy=%b valid=%b want 1,0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        sendWord(16'h3142, 16'h1234, 8'hFF, "basic");
    endtask

    task automatic test_equal();
        sendWord(16'h5555, 16'h5555, 8'hFF, "equal");
    endtask

    task automatic test_stall();
        sendWord(16'h0F0A, 16'h00AF, 8'b1111_1001, "stall");
    endtask

    task automatic test_reset_mid_sort();
        int sawValid;
        in_data  = 16'h3142;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset.idle rdy=%b valid=%b want 1,0", in_ready, out_valid);
        end
        sawValid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) sawValid++;
            tick();
        end
        checks++;
        if (sawValid != 0) begin
            errors++;
            $display("[TB] FAIL midreset.no_resume valid_cycles=%0d want=0", sawValid);
        end
        sendWord(16'h1234, 16'h1234, 8'hFF, "after_reset");
    endtask

    task automatic test_ignore_busy();
        int c;
        int sent;
        logic [3:0] exp;
        in_data   = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_data = 16'h5555;
        sent = 0;
        c = 0;
        while (sent < 4 && c < 40) begin
            if (out_valid === 1'b1) begin
                exp = expAt(16'h1234, sent);
                checks++;
                if (out_data !== exp || out_last !== (sent == 3)) begin
                    errors++;
                    $display("[TB] FAIL ignore.elem%0d data=%h last=%b want data=%h last=%b",
                             sent, out_data, out_last, exp, (sent == 3));
                end
                sent++;
            end
            tick();
            c++;
        end
        checks++;
        if (sent != 4) begin
            errors++;
            $display("[TB] FAIL ignore.timeout sent=%0d want=4", sent);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ignore.ready_after got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore.second_accept rdy=%b want=0", in_ready);
        end
        for (int e = 0; e < 6; e++) tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'h5 || out_last !== (k == 3)) begin
                errors++;
                $display("[TB] FAIL ignore.second%0d valid=%b data=%h last=%b want 1,5,%b",
                         k, out_valid, out_data, out_last, (k == 3));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equal();
        test_stall();
        test_reset_mid_sort();
        test_ignore_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
